// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory port bundle for mem_arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-ported fixed-latency memory
module mem_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int MAX_DM_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam logic [3:0] LAT    = 4'(MEM_LAT);
  localparam logic [3:0] BURST  = 4'(MAX_DM_BURST);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  dm_streak;
  logic        owner_dm;
  logic        owner_store;
  logic        killed;
  logic        mem_en, mem_we, if_ready, dm_ready;
  logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
  logic        any_req, grant_dm, kill_now;

  assign any_req  = bus.dm_req | bus.if_req;
  assign grant_dm = bus.dm_req & ~(bus.if_req & (dm_streak == BURST));
  // A kill only matters while a fetch owns the memory.
  assign kill_now = killed | (~owner_dm & bus.if_kill);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      dm_streak   <= 4'd0;
      owner_dm    <= 1'b0;
      owner_store <= 1'b0;
      killed      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      if_ready    <= 1'b0;
      dm_ready    <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      if_rdata    <= 32'd0;
      dm_rdata    <= 32'd0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dm    <= grant_dm;
            owner_store <= grant_dm & bus.dm_we;
            killed      <= 1'b0;
            mem_en      <= 1'b1;
            mem_we      <= grant_dm & bus.dm_we;
            mem_addr    <= grant_dm ? bus.dm_addr : bus.if_addr;
            if (grant_dm) begin
              mem_wdata <= bus.dm_wdata;
              if (!bus.if_req)
                dm_streak <= 4'd0;
              else if (dm_streak < BURST)
                dm_streak <= dm_streak + 4'd1;
            end else begin
              dm_streak <= 4'd0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt    <= LAT;
          killed <= kill_now;
          state  <= WAIT;
        end
        WAIT: begin
          cnt    <= cnt - 4'd1;
          killed <= kill_now;
          if (cnt == 4'd1) begin
            state <= RESP;
            if (owner_dm) begin
              if (!owner_store)
                dm_rdata <= bus.mem_rdata;
              dm_ready <= 1'b1;
            end else if (!kill_now) begin
              if_rdata <= bus.mem_rdata;
              if_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_ready  = if_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_ready  = dm_ready;
  assign bus.dm_rdata  = dm_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] glog[$];
  logic [7:0]  en_pipe = 8'd0;
  logic [31:0] addr_pipe [8];

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LAT(LAT), .MAX_DM_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'd0) ? 32'hE04F000F : (a ^ 32'hA5A50000);
  endfunction

  // Memory model: data is valid only in the cycle MEM_LAT after the strobe.
  always @(posedge clk) begin
    en_pipe      <= {en_pipe[6:0], bus.mem_en};
    addr_pipe[0] <= bus.mem_addr;
    for (int i = 1; i < 8; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign bus.mem_rdata = en_pipe[LAT-1] ? mem_fn(addr_pipe[LAT-1]) : 32'hBAD0BAD0;

  always @(negedge clk) if (bus.mem_en) glog.push_back(bus.mem_addr);

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.mem_en   !== 1'b0)  begin bad++; $display("FAIL rst_mem_en got=%h exp=0", bus.mem_en); end
    total++; if (bus.mem_we   !== 1'b0)  begin bad++; $display("FAIL rst_mem_we got=%h exp=0", bus.mem_we); end
    total++; if (bus.if_ready !== 1'b0)  begin bad++; $display("FAIL rst_if_ready got=%h exp=0", bus.if_ready); end
    total++; if (bus.dm_ready !== 1'b0)  begin bad++; $display("FAIL rst_dm_ready got=%h exp=0", bus.dm_ready); end
    total++; if (bus.mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if (bus.if_rdata !== 32'd0) begin bad++; $display("FAIL rst_if_rdata got=%h exp=0", bus.if_rdata); end
    total++; if (bus.dm_rdata !== 32'd0) begin bad++; $display("FAIL rst_dm_rdata got=%h exp=0", bus.dm_rdata); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_fetch;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); @(negedge clk);
      total++; if (bus.mem_en !== 1'(cyc == 1)) begin bad++; $display("FAIL fetch_mem_en c%0d got=%h exp=%h", cyc, bus.mem_en, cyc == 1); end
      total++; if (bus.if_ready !== 1'(cyc == 4)) begin bad++; $display("FAIL fetch_if_ready c%0d got=%h exp=%h", cyc, bus.if_ready, cyc == 4); end
      if (cyc == 1) begin
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL fetch_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL fetch_mem_we got=%h exp=0", bus.mem_we); end
      end
      if (cyc == 4) begin
        total++; if (bus.if_rdata !== 32'hE04F000F) begin bad++; $display("FAIL fetch_if_rdata got=%h exp=e04f000f", bus.if_rdata); end
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_both;
    int dm_at = -1;
    int if_at = -1;
    logic [31:0] g0, g1;
    @(posedge clk); #1;
    glog.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
    for (int cyc = 1; cyc <= 40 && if_at < 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (bus.dm_ready) begin dm_at = cyc; bus.dm_req = 1'b0; end
      if (bus.if_ready) begin if_at = cyc; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    g0 = (glog.size() > 0) ? glog[0] : 32'hFFFFFFFF;
    g1 = (glog.size() > 1) ? glog[1] : 32'hFFFFFFFF;
    total++; if (g0 !== 32'h20)  begin bad++; $display("FAIL both_first_grant got=%h exp=20", g0); end
    total++; if (g1 !== 32'h100) begin bad++; $display("FAIL both_second_grant got=%h exp=100", g1); end
    total++; if (dm_at != 4) begin bad++; $display("FAIL both_dm_latency got=%0d exp=4", dm_at); end
    total++; if (if_at != 9) begin bad++; $display("FAIL both_if_latency got=%0d exp=9", if_at); end
    total++; if (bus.dm_rdata !== 32'hA5A50020) begin bad++; $display("FAIL both_dm_rdata got=%h exp=a5a50020", bus.dm_rdata); end
    total++; if (bus.if_rdata !== 32'hA5A50100) begin bad++; $display("FAIL both_if_rdata got=%h exp=a5a50100", bus.if_rdata); end
  endtask

  task automatic test_burst;
    logic [31:0] exp_order [6];
    logic [31:0] g;
    exp_order[0] = 32'h2000; exp_order[1] = 32'h2000; exp_order[2] = 32'h2000;
    exp_order[3] = 32'h2000; exp_order[4] = 32'h1000; exp_order[5] = 32'h2000;
    @(posedge clk); #1;
    glog.delete();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    for (int cyc = 0; cyc < 60 && glog.size() < 6; cyc++) @(negedge clk);
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (glog.size() != 6) begin bad++; $display("FAIL burst_grant_count got=%0d exp=6", glog.size()); end
    for (int i = 0; i < 6; i++) begin
      g = (glog.size() > i) ? glog[i] : 32'hFFFFFFFF;
      total++; if (g !== exp_order[i]) begin bad++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, g, exp_order[i]); end
    end
  endtask

  task automatic test_store;
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h64; bus.dm_wdata = 32'd7;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); @(negedge clk);
      total++; if (bus.mem_en !== 1'(cyc == 1)) begin bad++; $display("FAIL store_mem_en c%0d got=%h exp=%h", cyc, bus.mem_en, cyc == 1); end
      total++; if (bus.mem_we !== 1'(cyc == 1)) begin bad++; $display("FAIL store_mem_we c%0d got=%h exp=%h", cyc, bus.mem_we, cyc == 1); end
      total++; if (bus.dm_ready !== 1'(cyc == 4)) begin bad++; $display("FAIL store_dm_ready c%0d got=%h exp=%h", cyc, bus.dm_ready, cyc == 4); end
      if (cyc == 1) begin
        total++; if (bus.mem_addr !== 32'h64) begin bad++; $display("FAIL store_mem_addr got=%h exp=64", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'd7) begin bad++; $display("FAIL store_mem_wdata got=%h exp=7", bus.mem_wdata); end
      end
      if (cyc == 4) begin
        total++; if (bus.dm_rdata !== 32'hA5A52000) begin bad++; $display("FAIL store_dm_rdata_hold got=%h exp=a5a52000", bus.dm_rdata); end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      end
    end
  endtask

  task automatic test_kill;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.dm_we = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin bus.if_kill = 1'b1; bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_addr = 32'h40; end
      if (cyc == 3) bus.if_kill = 1'b0;
      @(negedge clk);
      total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL kill_if_ready c%0d got=%h exp=0", cyc, bus.if_ready); end
      total++; if (bus.mem_en !== 1'(cyc == 1 || cyc == 6)) begin bad++; $display("FAIL kill_mem_en c%0d got=%h exp=%h", cyc, bus.mem_en, cyc == 1 || cyc == 6); end
      total++; if (bus.dm_ready !== 1'(cyc == 9)) begin bad++; $display("FAIL kill_dm_ready c%0d got=%h exp=%h", cyc, bus.dm_ready, cyc == 9); end
      if (cyc == 6) begin
        total++; if (bus.mem_addr !== 32'h40) begin bad++; $display("FAIL kill_dm_grant_addr got=%h exp=40", bus.mem_addr); end
      end
      if (cyc == 9) begin
        total++; if (bus.dm_rdata !== 32'hA5A50040) begin bad++; $display("FAIL kill_dm_rdata got=%h exp=a5a50040", bus.dm_rdata); end
        total++; if (bus.if_rdata !== 32'hA5A51000) begin bad++; $display("FAIL kill_if_rdata_hold got=%h exp=a5a51000", bus.if_rdata); end
        bus.dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin reset = 1'b0; bus.if_req = 1'b0; end
      if (cyc == 3) begin reset = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h50; end
      @(negedge clk);
      total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL rmid_if_ready c%0d got=%h exp=0", cyc, bus.if_ready); end
      total++; if (bus.mem_en !== 1'(cyc == 1 || cyc == 4)) begin bad++; $display("FAIL rmid_mem_en c%0d got=%h exp=%h", cyc, bus.mem_en, cyc == 1 || cyc == 4); end
      total++; if (bus.dm_ready !== 1'(cyc == 7)) begin bad++; $display("FAIL rmid_dm_ready c%0d got=%h exp=%h", cyc, bus.dm_ready, cyc == 7); end
      if (cyc == 3) begin
        total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'd0) begin bad++; $display("FAIL rmid_mem_outs got=%h/%h/%h exp=0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        total++; if ({bus.if_rdata, bus.dm_rdata} !== 64'd0) begin bad++; $display("FAIL rmid_rdata got=%h/%h exp=0", bus.if_rdata, bus.dm_rdata); end
      end
      if (cyc == 4) begin
        total++; if (bus.mem_addr !== 32'h50) begin bad++; $display("FAIL rmid_grant_addr got=%h exp=50", bus.mem_addr); end
      end
      if (cyc == 7) begin
        total++; if (bus.dm_rdata !== 32'hA5A50050) begin bad++; $display("FAIL rmid_dm_rdata got=%h exp=a5a50050", bus.dm_rdata); end
        bus.dm_req = 1'b0;
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_kill = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    test_reset;
    test_fetch;
    test_both;
    test_burst;
    test_store;
    test_kill;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..8.
REQ-002 Parameter MAX_DM_BURST, default 4, consecutive data-port grants allowed while a fetch waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 if_req  input  1  fetch request; held high with stable if_addr until if_ready or if_kill.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_kill  input  1  pipeline flush; cancels an in-flight fetch.
REQ-008 if_rdata  output  32  fetched instruction, valid while if_ready=1.
REQ-009 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-010 dm_req  input  1  data request; held high with stable dm_we/dm_addr/dm_wdata until dm_ready.
REQ-011 dm_we  input  1  1 = store, 0 = load.
REQ-012 dm_addr  input  32  data byte address.
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_rdata  output  32  load data, valid while dm_ready=1.
REQ-015 dm_ready  output  1  one-cycle completion pulse for data access (loads and stores).
REQ-016 mem_en  output  1  single-ported memory access strobe.
REQ-017 mem_we  output  1  memory write enable, only meaningful with mem_en=1.
REQ-018 mem_addr  output  32  memory address.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, WAIT, RESP; all outputs SHALL be registered.
REQ-022 IDLE: no request -> stay; any request -> grant per REQ-026, latch owner, register mem_addr/mem_we/mem_wdata, go ACCESS.
REQ-023 ACCESS: mem_en=1 for exactly this one cycle; load latency counter with MEM_LAT; go WAIT.
REQ-024 WAIT: decrement counter each cycle; at counter=1 capture mem_rdata into owner's rdata register, go RESP.
REQ-025 RESP: owner's ready=1 for exactly one cycle; go IDLE; request-to-ready latency when idle SHALL be MEM_LAT+2 cycles; requests are never sampled in RESP.
REQ-026 Arbitration: both requests -> data port wins unless dm_streak = MAX_DM_BURST, then fetch wins.
REQ-027 dm_streak (4 bits) SHALL increment on a data grant while if_req=1, clear on a fetch grant or a data grant with if_req=0, saturate at MAX_DM_BURST.
REQ-028 Stores: mem_we=1 in ACCESS, mem_wdata=dm_wdata; dm_ready still pulses per REQ-025; dm_rdata unchanged.
REQ-029 mem_we SHALL be 0 for all fetches and whenever mem_en=0.
REQ-030 if_kill=1 while owner is fetch in ACCESS/WAIT/RESP: if_ready SHALL stay 0, memory transaction completes silently, FSM returns to IDLE on normal schedule.
REQ-031 if_kill has no effect on a data-port transaction or in IDLE.
REQ-032 if_rdata/dm_rdata SHALL hold last captured value between ready pulses.

Reset
REQ-033 reset=0 at a rising edge SHALL force state IDLE, counter 0, dm_streak 0, mem_en 0, mem_we 0, if_ready 0, dm_ready 0, mem_addr/mem_wdata/if_rdata/dm_rdata 0.
REQ-034 reset mid-transaction SHALL abandon it: no ready pulse issued, returned data discarded; first grant possible in the first cycle after reset=1.

Verification
REQ-035 MEM_LAT=2, reset released, if_req=1 if_addr=0x0 at cycle 0, mem_rdata=0xE04F000F -> mem_en=1 mem_addr=0x0 cycle 1, if_ready=1 if_rdata=0xE04F000F cycle 4.
REQ-036 if_req and dm_req (load, 0x20) both rise in same IDLE cycle -> data granted first (mem_addr=0x20), fetch granted next IDLE.
REQ-037 dm_req and if_req held high continuously -> grant order dm,dm,dm,dm,if,dm,... (MAX_DM_BURST=4).
REQ-038 store dm_addr=0x64 dm_wdata=7 -> one cycle mem_en=1 mem_we=1 mem_addr=0x64 mem_wdata=7; dm_ready at MEM_LAT+2 cycles.
REQ-039 reset=0 during WAIT -> no ready pulse, all outputs 0 next cycle, fresh request afterwards serviced with normal latency.
REQ-040 if_kill=1 during WAIT of a fetch -> if_ready never asserts, FSM in IDLE at cycle MEM_LAT+3, pending dm_req granted there.
